// File: rtl/led_blinker_array.sv
// CH-channel LED blinker: each channel runs OFF, ON, continuous BLINK or a counted
// BURST of on/off pulses. It is reconfigured one channel at a time through a cfg handshake.
module led_blinker_array #(
  parameter int CH      = 4,
  parameter int CH_W    = 2,
  parameter int CNT_W   = 25,
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(24_999_999),
  parameter int BURST_W = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [1:0]         cfg_mode,
  input  logic [CNT_W-1:0]   cfg_period,
  input  logic [BURST_W-1:0] cfg_burst,
  output logic [CH-1:0]      led_out,
  output logic [CH-1:0]      tick,
  output logic [CH-1:0]      done,
  output logic [2*CH-1:0]    dbg_mode
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BURST = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [BURST_W:0]   REM_ONE = (BURST_W+1)'(1);

  mode_e              mode_q   [CH];
  mode_e              mode_d   [CH];
  logic [CNT_W-1:0]   period_q [CH];
  logic [CNT_W-1:0]   period_d [CH];
  logic [CNT_W-1:0]   cnt_q    [CH];
  logic [CNT_W-1:0]   cnt_d    [CH];
  logic [BURST_W:0]   rem_q    [CH];
  logic [BURST_W:0]   rem_d    [CH];
  logic [CH-1:0]      led_q, led_d, tick_q, tick_d, done_q, done_d;
  logic               ready_q, ready_d;
  logic               accept;

  // Handshake: a write is taken at any rising edge where cfg_valid and cfg_ready are
  // both high. cfg_ready then drops for exactly one cycle. Writes to cfg_ch >= CH
  // complete the handshake but change nothing.
  assign accept  = cfg_valid & ready_q;
  assign ready_d = ~accept;

  always_comb begin
    led_d  = led_q;
    tick_d = '0;
    done_d = '0;
    for (int i = 0; i < CH; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      cnt_d[i]    = cnt_q[i];
      rem_d[i]    = rem_q[i];
      if (accept && (cfg_ch == CH_W'(i))) begin
        mode_d[i]   = mode_e'(cfg_mode);
        period_d[i] = cfg_period;
        cnt_d[i]    = '0;
        rem_d[i]    = {cfg_burst, 1'b0};
        led_d[i]    = (cfg_mode == MODE_ON);
      end else if (en) begin
        case (mode_q[i])
          MODE_OFF: begin
            led_d[i] = 1'b0;
            cnt_d[i] = '0;
          end
          MODE_ON: begin
            led_d[i] = 1'b1;
            cnt_d[i] = '0;
          end
          MODE_BLINK: begin
            if (cnt_q[i] == period_q[i]) begin
              cnt_d[i]  = '0;
              led_d[i]  = ~led_q[i];
              tick_d[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
          default: begin
            // An empty burst (cfg_burst=0) finishes at once with no toggle.
            if (rem_q[i] == '0) begin
              mode_d[i] = MODE_OFF;
              led_d[i]  = 1'b0;
              done_d[i] = 1'b1;
            end else if (cnt_q[i] == period_q[i]) begin
              cnt_d[i]  = '0;
              led_d[i]  = ~led_q[i];
              tick_d[i] = 1'b1;
              rem_d[i]  = rem_q[i] - REM_ONE;
              if (rem_q[i] == REM_ONE) begin
                mode_d[i] = MODE_OFF;
                done_d[i] = 1'b1;
              end
            end else begin
              cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= CNT_MAX;
        cnt_q[i]    <= '0;
        rem_q[i]    <= '0;
      end
      led_q   <= '0;
      tick_q  <= '0;
      done_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      for (int i = 0; i < CH; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        cnt_q[i]    <= cnt_d[i];
        rem_q[i]    <= rem_d[i];
      end
      led_q   <= led_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    dbg_mode = '0;
    for (int i = 0; i < CH; i++) dbg_mode[2*i +: 2] = mode_q[i];
  end

  assign cfg_ready = ready_q;
  assign led_out   = led_q;
  assign tick      = tick_q;
  assign done      = done_q;

endmodule

// File: tb/tb_led_blinker_array.sv
// Bench for led_blinker_array. The model tracks enabled cycles elapsed since each write
// and derives LED level, ticks and burst completion from that count with plain division.
module tb_led_blinker_array;
  localparam int CH      = 4;
  localparam int CH_W    = 3;
  localparam int CNT_W   = 25;
  localparam int BURST_W = 8;
  localparam int W       = 5*CH + 1;

  logic               sys_clk = 1'b0;
  logic               sys_rst_n = 1'b0;
  logic               en = 1'b0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [CH_W-1:0]    cfg_ch = '0;
  logic [1:0]         cfg_mode = '0;
  logic [CNT_W-1:0]   cfg_period = '0;
  logic [BURST_W-1:0] cfg_burst = '0;
  logic [CH-1:0]      led_out, tick, done;
  logic [2*CH-1:0]    dbg_mode;

  led_blinker_array #(
    .CH(CH), .CH_W(CH_W), .CNT_W(CNT_W), .CNT_MAX(CNT_W'(24_999_999)), .BURST_W(BURST_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_burst(cfg_burst),
    .led_out(led_out), .tick(tick), .done(done), .dbg_mode(dbg_mode)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // scoreboard state
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model: mode 0..3, half-period, burst pulses, enabled cycles since write
  int m_mode[CH];
  int m_per[CH];
  int m_n[CH];
  int m_el[CH];
  bit m_led[CH];
  bit m_ready = 1'b1;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endfunction

  // driver: sets inputs for the next edge and pushes the outputs expected after it
  task automatic drive(input bit rst_n_v, input bit en_v, input bit valid_v,
                       input int ch_v, input int mode_v, input int per_v, input int burst_v);
    logic [CH-1:0]   t, d, l;
    logic [2*CH-1:0] md;
    bit acc;
    int ph;
    @(negedge sys_clk);
    sys_rst_n  = rst_n_v;
    en         = en_v;
    cfg_valid  = valid_v;
    cfg_ch     = CH_W'(ch_v);
    cfg_mode   = 2'(mode_v);
    cfg_period = CNT_W'(per_v);
    cfg_burst  = BURST_W'(burst_v);
    acc = valid_v && m_ready;
    t = '0;
    d = '0;
    for (int i = 0; i < CH; i++) begin
      if (!rst_n_v) begin
        m_mode[i] = 0; m_led[i] = 0; m_el[i] = 0; m_n[i] = 0;
      end else if (acc && ch_v == i) begin
        m_mode[i] = mode_v; m_per[i] = per_v; m_n[i] = burst_v; m_el[i] = 0;
        m_led[i]  = (mode_v == 1);
      end else if (en_v) begin
        if (m_mode[i] == 0) m_led[i] = 0;
        else if (m_mode[i] == 1) m_led[i] = 1;
        else if (m_mode[i] == 3 && m_n[i] == 0) begin
          m_mode[i] = 0; m_led[i] = 0; d[i] = 1;
        end else begin
          m_el[i]++;
          ph = m_el[i] / (m_per[i] + 1);
          m_led[i] = (ph % 2) == 1;
          if (m_el[i] % (m_per[i] + 1) == 0) begin
            t[i] = 1;
            if (m_mode[i] == 3 && ph == 2 * m_n[i]) begin
              d[i] = 1; m_mode[i] = 0;
            end
          end
        end
      end
    end
    m_ready = !rst_n_v || !acc;
    for (int i = 0; i < CH; i++) begin
      l[i] = m_led[i];
      md[2*i +: 2] = 2'(m_mode[i]);
    end
    exp_q.push_back({md, m_ready, d, t, l});
  endtask

  task automatic idle(input int n, input bit en_v);
    for (int k = 0; k < n; k++) drive(1, en_v, 0, 0, 0, 0, 0);
  endtask

  task automatic write(input int ch_v, input int mode_v, input int per_v, input int burst_v);
    drive(1, 1, 1, ch_v, mode_v, per_v, burst_v);
  endtask

  // monitor: one expected entry per edge, compared 1 time unit after it
  always @(posedge sys_clk) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("led_out",   32'(led_out),   32'(mon_e[CH-1:0]));
      check("tick",      32'(tick),      32'(mon_e[2*CH-1:CH]));
      check("done",      32'(done),      32'(mon_e[3*CH-1:2*CH]));
      check("cfg_ready", 32'(cfg_ready), 32'(mon_e[3*CH]));
      check("mode",      32'(dbg_mode),  32'(mon_e[W-1:3*CH+1]));
    end
  end

  initial begin
    for (int i = 0; i < CH; i++) begin
      m_mode[i] = 0; m_per[i] = 0; m_n[i] = 0; m_el[i] = 0; m_led[i] = 0;
    end
    // reset held with a write pending, then a quiet run
    for (int k = 0; k < 3; k++) drive(0, 1, 1, 1, 1, 0, 0);
    idle(20, 1);
    // continuous blink on ch1
    write(1, 2, 3, 0);
    idle(20, 1);
    // counted burst on ch2, then an empty burst on ch3
    write(2, 3, 1, 3);
    idle(16, 1);
    write(3, 3, 5, 0);
    idle(4, 1);
    // back-to-back writes with valid held high, last one out of range
    write(0, 1, 0, 0); write(0, 1, 0, 0);
    write(1, 1, 0, 0); write(1, 1, 0, 0);
    write(5, 2, 0, 0); write(5, 2, 0, 0);
    idle(4, 1);
    // freeze mid-blink, write during freeze, resume
    write(0, 2, 4, 0);
    idle(7, 1);
    idle(5, 0);
    drive(1, 0, 1, 3, 1, 0, 0);
    idle(4, 0);
    idle(15, 1);
    // restart at period 0, then reset in the middle of a burst
    write(0, 2, 0, 0);
    idle(10, 1);
    write(2, 3, 2, 4);
    idle(8, 1);
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(10, 1);
    // randomized traffic
    for (int k = 0; k < 600; k++)
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 5),
            $urandom_range(0, 4));
    idle(2, 1);
    @(posedge sys_clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
